// File: rtl/tauri_alu_pkg.sv
// Shared ALU instruction definitions used by the issue stage and its neighbours.
// The issue queue itself treats instructions as opaque words.
package tauri_alu_pkg;
  localparam int INSTR_W      = 32;
  localparam int ALU_DEST_LSB = 7;
  localparam int ALU_DEST_MSB = 11;
  localparam int ALU_SRC1_LSB = 15;
  localparam int ALU_SRC1_MSB = 19;
  localparam int ALU_SRC2_LSB = 20;
  localparam int ALU_SRC2_MSB = 24;

  typedef logic [INSTR_W-1:0] alu_instr_t;
endpackage

// File: rtl/alu_issue_queue_fifo.sv
// Register-based in-order FIFO with synchronous flush; storage is unreset,
// pointers and occupancy are cleared by the asynchronous reset.
module sync_fifo_reg
  import tauri_alu_pkg::*;
#(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// ALU issue stage: buffers decoded instructions and issues the head only when
// the hazard unit is clear and the ALU is ready; counts hazard-stalled cycles.
module alu_issue_queue
  import tauri_alu_pkg::*;
#(
  parameter int WIDTH       = INSTR_W,
  parameter int DEPTH       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [WIDTH-1:0]       in_instr_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [WIDTH-1:0]       alu_instr_o,
  output logic                   execute_o,
  input  logic                   hazard_i,
  input  logic                   alu_ready_i,
  input  logic                   flush_i,
  output logic                   empty_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);
  logic full;
  logic empty;
  logic push;
  logic stall_inc;
  logic [STALL_CNT_W-1:0] stall_q;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  // Readiness looks only at registered occupancy and flush, never at the pop.
  assign in_ready_o = !full && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign execute_o  = !empty && !hazard_i && alu_ready_i && !flush_i;
  assign stall_inc  = !empty && hazard_i && !flush_i;
  assign empty_o    = empty;
  assign stall_cycles_o = stall_q;

  sync_fifo_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (push),
    .pop   (execute_o),
    .wdata (in_instr_i),
    .rdata (alu_instr_o),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          stall_q <= '0;
    else if (stall_inc) stall_q <= sat_inc(stall_q);
  end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue, plus a narrow-counter instance for saturation.
module tb_alu_issue_queue;
  logic        clk;
  logic        rst_i;
  logic [31:0] in_instr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] alu_instr_o;
  logic        execute_o;
  logic        hazard_i;
  logic        alu_ready_i;
  logic        flush_i;
  logic        empty_o;
  logic [15:0] stall_cycles_o;

  logic [31:0] s_instr;
  logic        s_valid, s_ready, s_exec, s_hazard, s_alu_ready, s_flush, s_empty;
  logic [31:0] s_alu_instr;
  logic [1:0]  s_stall;

  int checks;
  int failures;

  alu_issue_queue #(.WIDTH(32), .DEPTH(4), .STALL_CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_instr_i(in_instr_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .alu_instr_o(alu_instr_o), .execute_o(execute_o),
    .hazard_i(hazard_i), .alu_ready_i(alu_ready_i), .flush_i(flush_i),
    .empty_o(empty_o), .stall_cycles_o(stall_cycles_o)
  );

  alu_issue_queue #(.WIDTH(32), .DEPTH(2), .STALL_CNT_W(2)) sat (
    .clk_i(clk), .rst_i(rst_i), .in_instr_i(s_instr), .in_valid_i(s_valid),
    .in_ready_o(s_ready), .alu_instr_o(s_alu_instr), .execute_o(s_exec),
    .hazard_i(s_hazard), .alu_ready_i(s_alu_ready), .flush_i(s_flush),
    .empty_o(s_empty), .stall_cycles_o(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_instr_i = '0; in_valid_i = 0; hazard_i = 0; alu_ready_i = 1; flush_i = 0;
    s_instr = '0; s_valid = 0; s_hazard = 0; s_alu_ready = 0; s_flush = 0;
    cyc(); cyc();
    rst_i = 1'b0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL reset_execute got=%b exp=0", execute_o); end
    checks++; if (alu_instr_o !== 32'h0) begin failures++; $display("FAIL reset_alu_instr got=%h exp=0", alu_instr_o); end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    checks++; if (stall_cycles_o !== 16'h0) begin failures++; $display("FAIL reset_stall got=%h exp=0", stall_cycles_o); end
    cyc();
  endtask

  task automatic test_single();
    in_instr_i = 32'h0000_1111; in_valid_i = 1; hazard_i = 0; alu_ready_i = 1;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready_o); end
    checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", execute_o); end
    cyc();
    in_valid_i = 0;
    #1;
    checks++; if (execute_o !== 1'b1) begin failures++; $display("FAIL single_execute got=%b exp=1", execute_o); end
    checks++; if (alu_instr_o !== 32'h0000_1111) begin failures++; $display("FAIL single_instr got=%h exp=00001111", alu_instr_o); end
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready2 got=%b exp=1", in_ready_o); end
    cyc();
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL single_empty_after got=%b exp=1", empty_o); end
    checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL single_exec_after got=%b exp=0", execute_o); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_q [4];
    exp_q = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    alu_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      in_instr_i = exp_q[i]; in_valid_i = 1;
      #1;
      checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready_o); end
      cyc();
    end
    in_instr_i = 32'hA000_0004; in_valid_i = 1;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready_o); end
    checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL full_alu_busy_exec got=%b exp=0", execute_o); end
    cyc();
    in_valid_i = 0; alu_ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (execute_o !== 1'b1) begin failures++; $display("FAIL drain_exec[%0d] got=%b exp=1", i, execute_o); end
      checks++; if (alu_instr_o !== exp_q[i]) begin failures++; $display("FAIL drain_instr[%0d] got=%h exp=%h", i, alu_instr_o, exp_q[i]); end
      cyc();
    end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_hazard();
    hazard_i = 1; alu_ready_i = 1; in_instr_i = 32'h0000_BEEF; in_valid_i = 1;
    #1;
    cyc();
    in_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL hazard_exec[%0d] got=%b exp=0", k, execute_o); end
      checks++; if (stall_cycles_o !== 16'(k)) begin failures++; $display("FAIL hazard_stall[%0d] got=%0d exp=%0d", k, stall_cycles_o, k); end
      cyc();
    end
    hazard_i = 0;
    #1;
    checks++; if (stall_cycles_o !== 16'd3) begin failures++; $display("FAIL hazard_stall_final got=%0d exp=3", stall_cycles_o); end
    checks++; if (execute_o !== 1'b1) begin failures++; $display("FAIL hazard_issue got=%b exp=1", execute_o); end
    checks++; if (alu_instr_o !== 32'h0000_BEEF) begin failures++; $display("FAIL hazard_instr got=%h exp=0000beef", alu_instr_o); end
    cyc();
    alu_ready_i = 0; hazard_i = 0;
    cyc(); cyc();
    checks++; if (stall_cycles_o !== 16'd3) begin failures++; $display("FAIL alu_busy_not_counted got=%0d exp=3", stall_cycles_o); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_q [5];
    exp_q = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    alu_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      in_instr_i = exp_q[i]; in_valid_i = 1;
      cyc();
    end
    in_instr_i = exp_q[4]; in_valid_i = 1; alu_ready_i = 1;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL fullpop_refuse got=%b exp=0", in_ready_o); end
    checks++; if (alu_instr_o !== exp_q[0]) begin failures++; $display("FAIL fullpop_head got=%h exp=%h", alu_instr_o, exp_q[0]); end
    cyc();
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL fullpop_accept got=%b exp=1", in_ready_o); end
    checks++; if (alu_instr_o !== exp_q[1]) begin failures++; $display("FAIL fullpop_head2 got=%h exp=%h", alu_instr_o, exp_q[1]); end
    cyc();
    in_valid_i = 0;
    for (int i = 2; i < 5; i++) begin
      #1;
      checks++; if (execute_o !== 1'b1 || alu_instr_o !== exp_q[i]) begin failures++; $display("FAIL fullpop_drain[%0d] got=%b/%h exp=1/%h", i, execute_o, alu_instr_o, exp_q[i]); end
      cyc();
    end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL fullpop_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_flush();
    alu_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      in_instr_i = 32'hC000_0000 + 32'(i); in_valid_i = 1;
      cyc();
    end
    flush_i = 1; in_instr_i = 32'hC000_0003; in_valid_i = 1; alu_ready_i = 1;
    #1;
    checks++; if (execute_o !== 1'b0) begin failures++; $display("FAIL flush_exec got=%b exp=0", execute_o); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready_o); end
    cyc();
    flush_i = 0; in_valid_i = 0;
    #1;
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty_o); end
    checks++; if (execute_o !== 1'b0 || alu_instr_o !== 32'h0) begin failures++; $display("FAIL flush_no_issue got=%b/%h exp=0/0", execute_o, alu_instr_o); end
    checks++; if (stall_cycles_o !== 16'd3) begin failures++; $display("FAIL flush_keeps_stall got=%0d exp=3", stall_cycles_o); end
    cyc();
    in_instr_i = 32'h0000_D00D; in_valid_i = 1;
    cyc();
    in_valid_i = 0;
    checks++; if (execute_o !== 1'b1 || alu_instr_o !== 32'h0000_D00D) begin failures++; $display("FAIL flush_restart got=%b/%h exp=1/0000d00d", execute_o, alu_instr_o); end
    cyc();
  endtask

  task automatic test_saturate();
    s_hazard = 1; s_alu_ready = 1; s_instr = 32'h0000_5A5A; s_valid = 1;
    cyc();
    s_valid = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (s_stall !== ((k > 3) ? 2'd3 : 2'(k))) begin failures++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", k, s_stall, (k > 3) ? 3 : k); end
      cyc();
    end
    checks++; if (s_exec !== 1'b0) begin failures++; $display("FAIL sat_exec got=%b exp=0", s_exec); end
  endtask

  task automatic test_async_reset();
    alu_ready_i = 0; hazard_i = 1;
    for (int i = 0; i < 2; i++) begin
      in_instr_i = 32'hE000_0000 + 32'(i); in_valid_i = 1;
      cyc();
    end
    in_valid_i = 0;
    cyc();
    checks++; if (stall_cycles_o === 16'd3) begin failures++; $display("FAIL pre_reset_stall got=%0d exp=not 3", stall_cycles_o); end
    #2;
    rst_i = 1;
    #1;
    checks++; if (empty_o !== 1'b1 || in_ready_o !== 1'b1) begin failures++; $display("FAIL async_rst_state got=%b/%b exp=1/1", empty_o, in_ready_o); end
    checks++; if (stall_cycles_o !== 16'h0 || s_stall !== 2'd0) begin failures++; $display("FAIL async_rst_stall got=%0d/%0d exp=0/0", stall_cycles_o, s_stall); end
    checks++; if (alu_instr_o !== 32'h0) begin failures++; $display("FAIL async_rst_instr got=%h exp=0", alu_instr_o); end
    #1;
    rst_i = 0; hazard_i = 0; alu_ready_i = 1;
    in_instr_i = 32'h0000_F00D; in_valid_i = 1;
    cyc();
    in_valid_i = 0;
    checks++; if (execute_o !== 1'b1 || alu_instr_o !== 32'h0000_F00D) begin failures++; $display("FAIL post_rst_issue got=%b/%h exp=1/0000f00d", execute_o, alu_instr_o); end
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_fill_drain();
    test_hazard();
    test_full_pop();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
Buffered issue stage directly upstream of the ALU hazard check. It accepts decoded ALU instructions from decode over a valid/ready handshake and holds them in a small in-order FIFO. It presents the head instruction to the hazard unit and ALU, and asserts execute only when the hazard unit reports no RAW/WAR conflict and the ALU can accept. It also keeps a saturating stall-cycle counter for performance analysis.

Parameters:
WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries; power of two, minimum 2
STALL_CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
in_instr_i  in  WIDTH  decoded ALU instruction from decode
in_valid_i  in  1  in_instr_i is valid
in_ready_o  out  1  queue can accept an instruction this cycle
alu_instr_o  out  WIDTH  head instruction, driven to the hazard unit and ALU
execute_o  out  1  head issues to the ALU this cycle
hazard_i  in  1  combinational hazard verdict on alu_instr_o
alu_ready_i  in  1  ALU can accept an instruction this cycle
flush_i  in  1  discard all queued instructions
empty_o  out  1  queue holds no entries
stall_cycles_o  out  STALL_CNT_W  saturating count of hazard-stalled cycles

Behaviour:
- Reset (async assert): count, rd_ptr, wr_ptr = 0; stall_cycles_o = 0; storage contents don't-care. Outputs then read: in_ready_o=1, execute_o=0, alu_instr_o=0, empty_o=1.
- Storage: DEPTH x WIDTH registers. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- in_ready_o = (count != DEPTH) && !flush_i. It depends only on registered count and flush_i, never on the pop, so there is no combinational path from hazard_i or alu_ready_i.
- Push occurs when in_valid_i && in_ready_o. The entry is written at wr_ptr and wr_ptr increments.
- alu_instr_o = mem[rd_ptr] when count != 0, else 0. Decode-to-issue latency is at least 1 cycle; there is no bypass.
- execute_o = (count != 0) && !hazard_i && alu_ready_i && !flush_i. This is combinational: head -> hazard unit -> execute_o is a single-cycle loop and is legal because the hazard unit is combinational only on the instruction and registered state.
- Pop occurs when execute_o=1; rd_ptr increments.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full: a push is refused even if a pop occurs in the same cycle. Throughput is still 1/cycle whenever count < DEPTH.
- Empty: execute_o=0 regardless of hazard_i. With push-only, the entry is visible at the head the next cycle.
- Flush: on a cycle with flush_i=1, execute_o=0 and no push occurs. On the next edge count, rd_ptr and wr_ptr = 0. stall_cycles_o is not cleared.
- Stall counter: increments when count != 0 && hazard_i && !flush_i. It saturates at all-ones. Cycles stalled only by alu_ready_i=0 are not counted.
- Reset mid-operation: the queue clears immediately. Any in-flight handshake in that cycle is lost. Decode must re-send.
- Ordering: strict FIFO; no reordering or bypass around a hazarded head.

Decomposition:
- Shared package tauri_alu_pkg holds:
  - INSTR_W = 32.
  - Field constants ALU_DEST_LSB/MSB, ALU_SRC1_LSB/MSB, ALU_SRC2_LSB/MSB.
  - typedef alu_instr_t (logic [INSTR_W-1:0]).
- The queue treats the instruction as opaque and does not decode fields.
- One sub-module is natural: sync_fifo_reg (parameterised register FIFO with count/full/empty and a flush input). alu_issue_queue wraps it with the issue gating and the stall counter.

Test Plan:
1. Reset, then push 0x0000_1111 with hazard_i=0 and alu_ready_i=1 -> in_ready_o=1 throughout; execute_o=1 with alu_instr_o=0x0000_1111 exactly 1 cycle after the push; empty_o=1 after.
2. Push 4 instructions with alu_ready_i=0 -> in_ready_o=0 after the 4th; a 5th push with in_valid_i=1 is not accepted; raising alu_ready_i drains in order, 1/cycle.
3. Queue the head, hold hazard_i=1 for 3 cycles, then 0 -> execute_o=0 for 3 cycles; stall_cycles_o advances 0->3; the head issues on cycle 4.
4. Full queue with simultaneous pop and in_valid_i=1 -> the push is refused that cycle; count=3 next cycle, then accepts.
5. Queue 3 entries, assert flush_i with a concurrent push -> execute_o=0 that cycle; empty_o=1 next cycle; the pushed instruction is never issued.
6. Preload stall_cycles_o to 0xFFFE (force) and hold hazard_i=1 for 3 cycles -> the counter reads 0xFFFF and stays; an async rst_i pulse mid-cycle clears all state before the next edge.
